// File: rtl/pong_pkg.sv
// Shared Pong constants: screen geometry, counter widths and the paddle FSM encoding.
package pong_pkg;

  localparam int H_BITS   = 10;
  localparam int V_BITS   = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } paddle_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a frame-sampled debounce counter.
// pressed reflects the accepted (debounced) level, active-high.
module btn_debounce #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic             sync1;
  logic             sync2;
  logic             acc_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // A change is only accepted after DEBOUNCE_FRAMES consecutive differing frame samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_n <= 1'b1;
      cnt   <= '0;
    end else if (tick) begin
      if (sync2 != acc_n) begin
        if (cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
          acc_n <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pressed = ~acc_n;

endmodule

// File: rtl/paddle_ctrl.sv
// Pong paddle engine: frame tick from vsync, debounced buttons, IDLE/UP/DOWN motion
// with hold-to-accelerate and window clamping, plus the registered pixel renderer.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int X_LEFT          = 13,
  parameter int X_WIDTH         = 9,
  parameter int HEIGHT          = 48,
  parameter int Y_MIN           = 10,
  parameter int Y_MAX           = 421,
  parameter int Y_RESET         = 216,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_MAX       = 8,
  parameter int ACCEL_FRAMES    = 4,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              up_n,
  input  logic              down_n,
  input  logic [H_BITS-1:0] hcount,
  input  logic [V_BITS-1:0] vcount,
  output logic              pix,
  output logic [V_BITS-1:0] paddle_y,
  output logic              moving
);

  localparam int SPEED_W = $clog2(SPEED_MAX + 1);
  localparam int HOLD_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  logic vs_s1, vs_s2, vs_d, tick;
  logic up_pressed, dn_pressed;
  logic cmd_up, cmd_dn;

  paddle_state_e        state, state_n;
  logic [SPEED_W-1:0]   speed, speed_n;
  logic [HOLD_W-1:0]    hold_cnt, hold_n;
  logic [V_BITS-1:0]    y_n;
  logic                 move_up, move_dn, clamped;
  logic [10:0]          y_ext, sp_ext;

  // vsync is treated as data: synchronised, then its falling edge becomes a 1-cycle tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_d  <= 1'b1;
      tick  <= 1'b0;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
      tick  <= vs_d & ~vs_s2;
    end
  end

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_n   (up_n),
    .pressed (up_pressed)
  );

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_dn (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_n   (down_n),
    .pressed (dn_pressed)
  );

  // Commands use the accepted states before this tick's debounce update (one frame of lag).
  assign cmd_up = up_pressed & ~dn_pressed;
  assign cmd_dn = dn_pressed & ~up_pressed;

  always_comb begin
    state_n = state;
    speed_n = speed;
    hold_n  = hold_cnt;
    y_n     = paddle_y;
    move_up = 1'b0;
    move_dn = 1'b0;
    clamped = 1'b0;
    y_ext   = {1'b0, paddle_y};
    sp_ext  = 11'(speed);

    case (state)
      ST_IDLE: begin
        if (cmd_up) begin
          state_n = ST_UP;
          move_up = 1'b1;
        end else if (cmd_dn) begin
          state_n = ST_DOWN;
          move_dn = 1'b1;
        end
      end
      ST_UP: begin
        if (cmd_up) begin
          move_up = 1'b1;
        end else begin
          state_n = ST_IDLE;
          speed_n = SPEED_W'(SPEED_MIN);
          hold_n  = '0;
        end
      end
      ST_DOWN: begin
        if (cmd_dn) begin
          move_dn = 1'b1;
        end else begin
          state_n = ST_IDLE;
          speed_n = SPEED_W'(SPEED_MIN);
          hold_n  = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        speed_n = SPEED_W'(SPEED_MIN);
        hold_n  = '0;
      end
    endcase

    if (move_up) begin
      if (y_ext < 11'(Y_MIN) + sp_ext) begin
        y_n     = V_BITS'(Y_MIN);
        clamped = 1'b1;
      end else begin
        y_n = V_BITS'(y_ext - sp_ext);
      end
    end else if (move_dn) begin
      if (y_ext + sp_ext > 11'(Y_MAX)) begin
        y_n     = V_BITS'(Y_MAX);
        clamped = 1'b1;
      end else begin
        y_n = V_BITS'(y_ext + sp_ext);
      end
    end

    // Hitting a bound restarts acceleration; otherwise every ACCEL_FRAMES moves add one line/frame.
    if (move_up || move_dn) begin
      if (clamped) begin
        speed_n = SPEED_W'(SPEED_MIN);
        hold_n  = '0;
      end else if (hold_cnt == HOLD_W'(ACCEL_FRAMES - 1)) begin
        hold_n = '0;
        if (speed != SPEED_W'(SPEED_MAX)) speed_n = speed + SPEED_W'(1);
      end else begin
        hold_n = hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      speed    <= SPEED_W'(SPEED_MIN);
      hold_cnt <= '0;
      paddle_y <= V_BITS'(Y_RESET);
    end else if (tick) begin
      state    <= state_n;
      speed    <= speed_n;
      hold_cnt <= hold_n;
      paddle_y <= y_n;
    end
  end

  assign moving = (state == ST_UP) || (state == ST_DOWN);

  // Exclusive upper bounds in 11 bits so exactly X_WIDTH columns and HEIGHT lines light.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix <= 1'b0;
    end else begin
      pix <= ({1'b0, hcount} >= 11'(X_LEFT)) &&
             ({1'b0, hcount} <  11'(X_LEFT + X_WIDTH)) &&
             (vcount >= paddle_y) &&
             ({1'b0, vcount} < {1'b0, paddle_y} + 11'(HEIGHT));
    end
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised Pong paddle engine: debounces two active-low buttons, moves a paddle once per video frame with hold-to-accelerate, clamps it to a vertical window, and renders its pixel mask from the VGA counters. All logic sits in the `clk` domain, with `vsync` synchronised and edge-detected rather than used as a clock. One instance per player; `pix` feeds the colour mux beside the ball and score renderers.

## Interface
- `X_LEFT`, 13: first paddle column (inclusive)
- `X_WIDTH`, 9: paddle width in pixels
- `HEIGHT`, 48: paddle height in lines
- `Y_MIN`, 10: smallest legal `paddle_y`
- `Y_MAX`, 421: largest legal `paddle_y`; legal only if `Y_MAX + HEIGHT <= 480`
- `Y_RESET`, 216: `paddle_y` after reset
- `SPEED_MIN`, 2: lines per frame when motion starts
- `SPEED_MAX`, 8: speed saturation value
- `ACCEL_FRAMES`, 4: moving frames per +1 speed step
- `DEBOUNCE_FRAMES`, 2: consecutive equal frame samples needed to accept a button change
- `clk  in  1`: pixel clock
- `rst  in  1`: reset, asynchronous, active-high
- `vsync  in  1`: VGA vsync, active-low, asynchronous to `clk`
- `up_n  in  1`: up button, active-low, asynchronous
- `down_n  in  1`: down button, active-low, asynchronous
- `hcount  in  10`: current pixel column
- `vcount  in  10`: current pixel line
- `pix  out  1`: paddle pixel, registered
- `paddle_y  out  10`: top line of the paddle, for ball collision logic
- `moving  out  1`: high while state is UP or DOWN

## Operation
- **Sync.** `vsync`, `up_n` and `down_n` each pass through 2-FF synchronisers.
- **Frame tick.** `tick` is a 1-cycle pulse on the falling edge of synchronised `vsync`.
- **Debounce.** Per button, the synchronised level is sampled only on `tick`.
  - If the sample differs from the accepted state, a counter increments; otherwise the counter clears.
  - When the counter reaches `DEBOUNCE_FRAMES`, the accepted state flips and the counter clears.
- **Command.** Built from the accepted states *before* this tick's debounce update, so there is one frame of lag.
  - `cmd_up` = up pressed and down released.
  - `cmd_dn` = down pressed and up released.
  - Both pressed or neither pressed = no command.
- **FSM states.** IDLE, UP, DOWN; evaluated only on `tick`.
  - IDLE: `cmd_up` → UP, `cmd_dn` → DOWN, else stay. On entry: `speed = SPEED_MIN`, `hold_cnt = 0`.
  - UP and DOWN: a matching command keeps the state. No command → IDLE. The opposite command → IDLE for that frame, with no move and speed reset; the opposite state is entered on the next tick.
- **Move.** In UP or DOWN with a matching command, `paddle_y` moves by `speed` on that tick.
  - Arithmetic uses 11 bits.
  - UP: if `paddle_y < Y_MIN + speed` then `paddle_y = Y_MIN`, else `paddle_y -= speed`.
  - DOWN: if `paddle_y + speed > Y_MAX` then `paddle_y = Y_MAX`, else `paddle_y += speed`.
  - Reaching a bound by clamping resets `speed` to `SPEED_MIN` and `hold_cnt` to 0. The state is unchanged.
- **Acceleration.** After each unclamped move, `hold_cnt` increments.
  - At `ACCEL_FRAMES - 1` it wraps to 0 and `speed` increments, saturating at `SPEED_MAX`.
  - The new speed applies from the next move.
- **Render.** `pix` is high when `X_LEFT <= hcount < X_LEFT + X_WIDTH` and `paddle_y <= vcount < paddle_y + HEIGHT`. Exactly `HEIGHT` lines are lit, with exclusive upper bounds.
- **Reset values.** `pix = 0`, `paddle_y = Y_RESET`, `moving = 0`, state IDLE, `speed = SPEED_MIN`, `hold_cnt = 0`, debounce counters 0, accepted buttons released, synchronisers 1.
  - Reset mid-move takes effect immediately (asynchronous); the next tick starts from IDLE.

## Timing
- `tick` asserts 3 clk cycles after the `vsync` falling edge (2 sync stages plus edge register).
- `paddle_y`, `moving`, the FSM and `speed` update only in the cycle after `tick`. They are stable for the whole active frame, so there is no tearing.
- Press-to-first-move: the press is accepted at tick `DEBOUNCE_FRAMES` after sampling starts, and the first move occurs on the following tick.
- `pix` latency is 1 clk from `hcount`/`vcount`.

## Structure
- Shared `pong_pkg` holds `H_BITS` = `V_BITS` = 10, `SCREEN_W` = 640, `SCREEN_H` = 480, and the FSM state enum.
- Sub-module `btn_debounce`: sync, frame-sampled counter and accepted state, parameter `DEBOUNCE_FRAMES`. It is instantiated twice.
- The FSM, position datapath and renderer stay in `paddle_ctrl`.

## Test plan
All scenarios use default parameters.
- **Reset, then up held.** Reset; hold `up_n = 0` from tick 0. `paddle_y` stays 216 through tick 2, is 214 after tick 3, 208 after tick 6, and 205 after tick 7. `moving = 1` from tick 3.
- **Bounce rejection.** `up_n` low for 1 frame, high for 1, low for 1. `paddle_y` stays 216 and `moving` stays 0.
- **Clamp at top.** `paddle_y = 12`, speed 8, up held. Next tick `paddle_y = 10` and speed is 2. Further ticks hold 10 with `moving = 1`.
- **Both buttons and reversal.** Both pressed gives IDLE with no motion. Switching from up to down gives one frame IDLE, then DOWN at speed 2.
- **Render.** With `paddle_y = 216`: (`hcount = 13`, `vcount = 216`) gives `pix = 1` one cycle later. (22, 216) gives 0, (13, 264) gives 0, and (21, 263) gives 1.
- **Async reset mid-move.** `rst` asserted mid-frame with speed 5 at `paddle_y = 300`. `paddle_y = 216`, `moving = 0` and `pix = 0` immediately, with no clock edge needed.
